vga_color_sched: RTL and testbench
==================================

Name: vga_color_sched

Overview:
- Controller that decides which 3-bit colour the VGA datapath shows, and when that colour changes.
- Two requesters share the single displayed-colour register:
  - the manual key path: a debounced set pulse plus a latched RGB value;
  - an auto-cycle timer counted in frames.
- Colour changes are committed only at a frame boundary (vsync falling edge), so a frame never tears.
- Sits between the key processor / debouncer and the blanking stage that drives the colour pins.

Parameters:
- AUTO_FRAMES, 60, frames between auto-cycle steps; legal range 1..1023.
- HOLD_FRAMES, 180, frames for which auto-cycle is suppressed after a manual commit; 0 means no hold.
- INIT_COLOR, 3'b111, colour loaded at reset.

Ports:
- sysclk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- vsync  in  1  vertical sync from the VGA timing block; active-low pulse, synchronous to sysclk.
- disp_on  in  1  high while inside the visible area.
- man_req  in  1  single-cycle pulse from the debounced set key.
- man_color  in  3  {R,G,B} value sampled on man_req.
- auto_en  in  1  enables auto-cycling (board switch); level signal.
- color  out  3  blank-gated colour to the pins.
- commit  out  1  one-cycle pulse when the displayed colour register is updated.
- pending  out  1  high while a manual request waits for a frame boundary.
- frame_cnt  out  10  frames since the last commit.

Behaviour:
- Reset (reset=0), asynchronous:
  - cur_color=INIT_COLOR; color=0; commit=0; pending=0;
  - frame_cnt=0; hold counter=0; FSM=IDLE; vsync history register=1.
- Frame boundary fb:
  - vsync is registered once (vs_q);
  - fb=1 for exactly one cycle when vs_q=1 and vsync=0.
- FSM states IDLE, PEND, COMMIT:
  - IDLE: man_req -> PEND; latch man_color into pend_color.
  - IDLE: fb with auto-due -> COMMIT; next = cur_color+1, modulo 8 (7 wraps to 0).
  - PEND: further man_req overwrites pend_color (latest wins); pending=1 throughout PEND.
  - PEND: fb -> COMMIT; next = pend_color.
  - COMMIT (one cycle): cur_color<=next; commit=1; frame_cnt<=0.
    - Manual source: hold counter<=HOLD_FRAMES.
    - Then go to PEND if a man_req arrived during COMMIT, else IDLE.
- Auto-due condition, all of the following:
  - auto_en=1;
  - hold counter=0;
  - frame_cnt ≥ AUTO_FRAMES-1 at fb.
- Arbitration: manual has priority over auto.
  - PEND at fb always commits the manual colour.
  - The auto step is dropped, not deferred; frame_cnt restarts.
- Simultaneous events:
  - man_req and fb in the same cycle while in IDLE: the request is latched (PEND) and commits at the next fb.
  - The current fb may still perform an auto step. In that case pend_color is latched and the auto colour commits now.
- Counters on each fb that does not commit:
  - frame_cnt increments, saturating at 1023;
  - hold counter decrements if nonzero.
- auto_en is sampled only at fb. Deasserting it never changes cur_color.
- Output stage, registered, 1 cycle latency: color <= disp_on ? cur_color : 3'b000.
- No combinational path from any input to any output.

Decomposition:
- Shared package vga_pkg:
  - FSM state encoding (IDLE=2'd0, PEND=2'd1, COMMIT=2'd2);
  - COLOR_W=3;
  - FRAME_CNT_W=10.
- Natural sub-module: vga_frame_edge.
  - vsync register and fb pulse generation.
  - Reused by other frame-synchronous blocks.
- All else stays in one module.

Test Plan:
- Reset with vsync toggling and disp_on=1 -> color=3'b111 after the first clock following release; commit and pending remain 0.
- man_req with man_color=3'b010 mid-frame -> pending=1 until the next vsync fall; then commit pulses 1 cycle, and color=010 during the next visible cycles.
- Two man_req (001, then 100) in one frame -> one commit only; displayed colour=100.
- auto_en=1, AUTO_FRAMES=2, HOLD_FRAMES=0, start colour 110 -> sequence 111, 000, 001 on every 2nd fb.
- auto_en=1, AUTO_FRAMES=1, HOLD_FRAMES=3, manual 011 committed -> no auto commit for 3 fb; 100 commits on the 4th.
- reset asserted while PEND -> pending=0, color=0 immediately; after release, cur_color=111 and the old request is discarded.
- disp_on=0 -> color=000 regardless of cur_color.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared FSM encoding and widths for the VGA colour scheduler and its frame-synchronous helpers
package vga_pkg;
  localparam int COLOR_W = 3;
  localparam int FRAME_CNT_W = 10;
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, COMMIT = 2'd2} state_t;
  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [FRAME_CNT_W-1:0] fcnt_t;
endpackage

// File: rtl/vga_color_sched_if.sv
// vga_color_sched_if: scheduler bus; in: vsync, disp_on, man_req, man_color, auto_en; out: color, commit, pending, frame_cnt
interface vga_color_sched_if;
  import vga_pkg::*;
  logic   vsync;
  logic   disp_on;
  logic   man_req;
  color_t man_color;
  logic   auto_en;
  color_t color;
  logic   commit;
  logic   pending;
  fcnt_t  frame_cnt;
  modport master (
    output vsync, disp_on, man_req, man_color, auto_en,
    input  color, commit, pending, frame_cnt
  );
  modport slave (
    input  vsync, disp_on, man_req, man_color, auto_en,
    output color, commit, pending, frame_cnt
  );
endinterface

// File: rtl/vga_frame_edge.sv
// vga_frame_edge: one-cycle frame-boundary pulse fb on vsync falling edge; in: sysclk, reset (async, active-low), vsync; out: fb
module vga_frame_edge (
  input  logic sysclk,
  input  logic reset,
  input  logic vsync,
  output logic fb
);
  logic vs_q;
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) vs_q <= 1'b1;
    else vs_q <= vsync;
  assign fb = vs_q & ~vsync;
endmodule

// File: rtl/vga_color_sched.sv
// vga_color_sched: commits manual/auto colour changes on frame boundaries; in: sysclk, reset (async, active-low), bus.slave
module vga_color_sched
  import vga_pkg::*;
#(
  parameter int     AUTO_FRAMES = 60,
  parameter int     HOLD_FRAMES = 180,
  parameter color_t INIT_COLOR  = 3'b111
) (
  input logic              sysclk,
  input logic              reset,
  vga_color_sched_if.slave bus
);
  localparam fcnt_t AUTO_LAST = fcnt_t'(AUTO_FRAMES - 1);
  localparam fcnt_t HOLD_INIT = fcnt_t'(HOLD_FRAMES);
  state_t state, state_n;
  color_t cur_color, pend_color, color_q;
  fcnt_t  frame_cnt, hold_cnt;
  logic   fb, auto_due, tick, man_src, wait_q;
  vga_frame_edge u_edge (
    .sysclk (sysclk),
    .reset  (reset),
    .vsync  (bus.vsync),
    .fb     (fb)
  );
  assign auto_due = bus.auto_en && hold_cnt == '0 && frame_cnt >= AUTO_LAST;
  // man_req is always captured into pend_color; state decides when it is committed
  always_comb begin
    state_n = state;
    tick = 1'b0;
    case (state)
      IDLE: begin
        tick = fb & ~auto_due;
        state_n = (fb & auto_due) ? COMMIT : bus.man_req ? PEND : IDLE;
      end
      PEND: state_n = fb ? COMMIT : PEND;
      COMMIT: state_n = (wait_q | bus.man_req) ? PEND : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // wait_q remembers a request that arrived alongside an auto step, so it is served after the commit
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) begin
      cur_color  <= INIT_COLOR;
      pend_color <= '0;
      color_q    <= '0;
      frame_cnt  <= '0;
      hold_cnt   <= '0;
      man_src    <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      color_q <= bus.disp_on ? cur_color : '0;
      if (bus.man_req) pend_color <= bus.man_color;
      if (state != COMMIT && state_n == COMMIT) begin
        man_src <= state == PEND;
        wait_q  <= state == IDLE && bus.man_req;
      end
      if (state == COMMIT) begin
        cur_color <= man_src ? pend_color : cur_color + 1'b1;
        frame_cnt <= '0;
        if (man_src) hold_cnt <= HOLD_INIT;
      end else if (tick) begin
        frame_cnt <= (&frame_cnt) ? frame_cnt : frame_cnt + 1'b1;
        hold_cnt  <= (hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;
      end
    end
  assign bus.color     = color_q;
  assign bus.commit    = state == COMMIT;
  assign bus.pending   = state == PEND;
  assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_vga_color_sched.sv
// tb_vga_color_sched: table, directed and randomized checks of three differently parameterised schedulers
module tb_vga_color_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b1;
  logic disp_on = 1'b1;
  logic man_req = 1'b0;
  logic auto_en = 1'b0;
  logic [2:0] man_color = 3'b000;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  vga_color_sched_if i0 ();
  vga_color_sched_if i1 ();
  vga_color_sched_if i2 ();
  assign i0.vsync = vsync;
  assign i1.vsync = vsync;
  assign i2.vsync = vsync;
  assign i0.disp_on = disp_on;
  assign i1.disp_on = disp_on;
  assign i2.disp_on = disp_on;
  assign i0.man_req = man_req;
  assign i1.man_req = man_req;
  assign i2.man_req = man_req;
  assign i0.man_color = man_color;
  assign i1.man_color = man_color;
  assign i2.man_color = man_color;
  assign i0.auto_en = auto_en;
  assign i1.auto_en = auto_en;
  assign i2.auto_en = auto_en;
  vga_color_sched u0 (.sysclk(clk), .reset(rst_n), .bus(i0));
  vga_color_sched #(.AUTO_FRAMES(2), .HOLD_FRAMES(0), .INIT_COLOR(3'b110)) u1 (.sysclk(clk), .reset(rst_n), .bus(i1));
  vga_color_sched #(.AUTO_FRAMES(1), .HOLD_FRAMES(3), .INIT_COLOR(3'b111)) u2 (.sysclk(clk), .reset(rst_n), .bus(i2));
  logic [2:0] o_col [3];
  logic       o_com [3];
  logic       o_pend [3];
  logic [9:0] o_fc [3];
  assign o_col[0] = i0.color;
  assign o_col[1] = i1.color;
  assign o_col[2] = i2.color;
  assign o_com[0] = i0.commit;
  assign o_com[1] = i1.commit;
  assign o_com[2] = i2.commit;
  assign o_pend[0] = i0.pending;
  assign o_pend[1] = i1.pending;
  assign o_pend[2] = i2.pending;
  assign o_fc[0] = i0.frame_cnt;
  assign o_fc[1] = i1.frame_cnt;
  assign o_fc[2] = i2.frame_cnt;
  // reference model: displayed colour, one queued manual request, one scheduled commit per instance
  int af [3];
  int hf [3];
  logic [2:0] init_c [3];
  logic [2:0] m_cur [3];
  logic [2:0] m_col [3];
  logic [2:0] m_pc [3];
  logic [2:0] m_cv [3];
  bit m_cn [3];
  bit m_cm [3];
  bit m_pd [3];
  bit m_vp [3];
  int m_fc [3];
  int m_hold [3];
  int ncom [3];
  typedef struct {
    logic       vs;
    logic       don;
    logic       req;
    logic [2:0] mcol;
    logic [2:0] ecol;
    logic       ecom;
    logic       epend;
    int         efc;
  } vec_t;
  vec_t tbl [16];
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    for (int d = 0; d < 3; d++) begin
      m_cur[d] = init_c[d];
      m_col[d] = 3'b000;
      m_pc[d] = 3'b000;
      m_cv[d] = 3'b000;
      m_cn[d] = 1'b0;
      m_cm[d] = 1'b0;
      m_pd[d] = 1'b0;
      m_vp[d] = 1'b1;
      m_fc[d] = 0;
      m_hold[d] = 0;
    end
  endtask
  task automatic m_step();
    for (int d = 0; d < 3; d++) begin
      bit mfb;
      mfb = m_vp[d] && !vsync;
      m_col[d] = disp_on ? m_cur[d] : 3'b000;
      if (m_cn[d]) begin
        m_cur[d] = m_cv[d];
        m_fc[d] = 0;
        if (m_cm[d]) m_hold[d] = hf[d];
        m_cn[d] = 1'b0;
        if (man_req) begin m_pd[d] = 1'b1; m_pc[d] = man_color; end
      end else if (mfb && m_pd[d]) begin
        m_cn[d] = 1'b1;
        m_cm[d] = 1'b1;
        m_cv[d] = man_req ? man_color : m_pc[d];
        m_pd[d] = 1'b0;
      end else if (mfb && auto_en && m_hold[d] == 0 && m_fc[d] >= af[d] - 1) begin
        m_cn[d] = 1'b1;
        m_cm[d] = 1'b0;
        m_cv[d] = m_cur[d] + 3'd1;
        if (man_req) begin m_pd[d] = 1'b1; m_pc[d] = man_color; end
      end else begin
        if (mfb) begin
          if (m_fc[d] < 1023) m_fc[d]++;
          if (m_hold[d] > 0) m_hold[d]--;
        end
        if (man_req) begin m_pd[d] = 1'b1; m_pc[d] = man_color; end
      end
      m_vp[d] = vsync;
    end
  endtask
  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("u%0d color", d), o_col[d], m_col[d]);
      chk($sformatf("u%0d commit", d), o_com[d], m_cn[d]);
      chk($sformatf("u%0d pending", d), o_pend[d], m_pd[d] && !m_cn[d]);
      chk($sformatf("u%0d frame_cnt", d), o_fc[d], m_fc[d]);
    end
  endtask
  task automatic step(input logic vs, input logic don, input logic req, input logic [2:0] mc, input logic ae);
    vsync = vs;
    disp_on = don;
    man_req = req;
    man_color = mc;
    auto_en = ae;
    m_step();
    @(negedge clk);
    check_all();
    for (int d = 0; d < 3; d++) ncom[d] += int'(o_com[d]);
  endtask
  task automatic frame(input logic ae);
    step(1'b0, 1'b1, 1'b0, 3'b000, ae);
    step(1'b0, 1'b1, 1'b0, 3'b000, ae);
    repeat (8) step(1'b1, 1'b1, 1'b0, 3'b000, ae);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    man_req = 1'b0;
    m_reset();
    repeat (3) begin
      vsync = ~vsync;
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    for (int d = 0; d < 3; d++) ncom[d] = 0;
  endtask
  task automatic rand_run(input int n, input int req_mod);
    repeat (n) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, req_mod - 1) == 0,
                    3'($urandom), $urandom_range(0, 7) != 0);
  endtask
  initial begin
    logic [2:0] exp_a [6];
    logic [2:0] exp_b [6];
    int com_a [6];
    int com_b [6];
    af = '{60, 2, 1};
    hf = '{180, 0, 3};
    init_c = '{3'b111, 3'b110, 3'b111};
    exp_a = '{3'b110, 3'b111, 3'b111, 3'b000, 3'b000, 3'b001};
    com_a = '{0, 1, 0, 1, 0, 1};
    exp_b = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b100, 3'b101};
    com_b = '{1, 0, 0, 0, 1, 1};
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 3'b010, 3'b111, 1'b0, 1'b1, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 3'b001, 3'b010, 1'b0, 1'b1, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 3'b100, 3'b010, 1'b0, 1'b1, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'b000, 3'b010, 1'b1, 1'b0, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 1};
    m_reset();
    @(negedge clk);
    do_reset();
    chk("reset release color", o_col[0], 3'b111);
    chk("reset release commit", o_com[0], 1'b0);
    chk("reset release pending", o_pend[0], 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].vs, tbl[i].don, tbl[i].req, tbl[i].mcol, 1'b0);
      chk($sformatf("tbl%0d color", i), o_col[0], tbl[i].ecol);
      chk($sformatf("tbl%0d commit", i), o_com[0], tbl[i].ecom);
      chk($sformatf("tbl%0d pending", i), o_pend[0], tbl[i].epend);
      chk($sformatf("tbl%0d frame_cnt", i), o_fc[0], tbl[i].efc);
    end
    do_reset();
    for (int k = 0; k < 6; k++) begin
      ncom[1] = 0;
      frame(1'b1);
      chk($sformatf("auto2 frame%0d color", k + 1), o_col[1], exp_a[k]);
      chk($sformatf("auto2 frame%0d commits", k + 1), ncom[1], com_a[k]);
    end
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    step(1'b1, 1'b1, 1'b1, 3'b011, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    chk("hold pending", o_pend[2], 1'b1);
    for (int k = 0; k < 6; k++) begin
      ncom[2] = 0;
      frame(1'b1);
      chk($sformatf("hold frame%0d color", k + 1), o_col[2], exp_b[k]);
      chk($sformatf("hold frame%0d commits", k + 1), ncom[2], com_b[k]);
    end
    step(1'b1, 1'b1, 1'b1, 3'b010, 1'b0);
    chk("pre-reset pending", o_pend[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async reset pending", o_pend[0], 1'b0);
    chk("async reset color", o_col[0], 3'b000);
    m_reset();
    @(negedge clk);
    check_all();
    vsync = 1'b1;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    chk("post-reset color", o_col[0], 3'b111);
    ncom[0] = 0;
    frame(1'b0);
    chk("discarded request commits", ncom[0], 0);
    chk("discarded request color", o_col[0], 3'b111);
    repeat (1050) begin
      step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
      step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    end
    for (int d = 0; d < 3; d++) chk($sformatf("u%0d frame_cnt saturation", d), o_fc[d], 10'd1023);
    rand_run(3000, 8);
    rand_run(3000, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
